// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - instruction memory with a power-up clear sequence, program load port and a registered fetch port
module instr_mem #(
  parameter int                 ADDR_W    = 5,
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD  = 32'h0000_0013,
  parameter logic [DATA_W-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              halted
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_word;
  logic                fetch_take;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Write-first bypass: a same-cycle program write to the fetched address wins over the array.
  assign rd_word    = (prog_we && (prog_addr == fetch_addr)) ? prog_data : mem[fetch_addr];
  assign fetch_take = (state == RUN) && fetch_req && !stall;

  // Next state, ready, and write-port steering; the clear sequence owns the write port while active.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = prog_addr;
    mem_wdata  = prog_data;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = NOP_WORD;
        if (clr_cnt == '1) state_next = RUN;
      end
      RUN: begin
        ready  = 1'b1;
        mem_we = prog_we;
        if (fetch_take && (rd_word == HALT_WORD)) state_next = HALT;
      end
      HALT: begin
        ready  = 1'b1;
        mem_we = prog_we;
      end
      default: state_next = CLEAR;
    endcase
  end

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Clear address counter, walks 0 .. DEPTH-1 once per clear sequence.
  always_ff @(posedge clk) begin
    if (rst)                 clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + CNT_ONE;
  end

  // Single memory write port; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Fetch output register: capture on accepted fetch, idle to NOP, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          instr       <= NOP_WORD;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
        RUN: begin
          if (!stall) begin
            if (fetch_req) begin
              instr       <= rd_word;
              instr_valid <= 1'b1;
            end else begin
              instr       <= NOP_WORD;
              instr_valid <= 1'b0;
            end
          end
          if (state_next == HALT) halted <= 1'b1;
        end
        HALT: begin
          if (!stall) begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
          end
          halted <= 1'b1;
        end
        default: begin
          instr       <= NOP_WORD;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - directed self-checking bench for instr_mem
module tb_instr_mem;

  localparam int          ADDR_W = 5;
  localparam int          DATA_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] HLT    = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              ready;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              halted;

  int checks = 0;
  int errors = 0;

  instr_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .ready       (ready),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects to be entered in the first clear cycle; drives junk writes/fetches that must be ignored.
  task automatic clear_seq();
    for (int i = 0; i < 32; i++) begin
      check("clear_ready", {31'b0, ready}, 32'd0);
      check("clear_valid", {31'b0, instr_valid}, 32'd0);
      check("clear_instr", instr, NOP);
      fetch_req  = 1'b1;
      fetch_addr = 5'(i);
      prog_we    = (i >= 2);
      prog_addr  = 5'd0;
      prog_data  = 32'hDEAD_BEEF;
      step();
    end
    prog_we   = 1'b0;
    fetch_req = 1'b0;
    check("clear_done_ready", {31'b0, ready}, 32'd1);
  endtask

  task automatic fetch(input logic [4:0] a, input logic [31:0] exp, input string tag);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req  = 1'b0;
    check(tag, instr, exp);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
    step();
    rst = 1'b0;
    check("rst_halted", {31'b0, halted}, 32'd0);
    clear_seq();

    // every word reads back as NOP after clear
    for (int i = 0; i < 32; i++) fetch(5'(i), NOP, "clear_fetch");
    step();
    check("idle_valid", {31'b0, instr_valid}, 32'd0);
    check("idle_instr", instr, NOP);

    // load and fetch
    write(5'd0, 32'h0040_0513);
    write(5'd1, 32'h0140_00EF);
    write(5'd2, 32'h00A0_0593);
    fetch(5'd0, 32'h0040_0513, "load_fetch0");
    fetch(5'd1, 32'h0140_00EF, "load_fetch1");

    // same-address bypass
    prog_we = 1'b1; prog_addr = 5'd7; prog_data = 32'hFF81_0113;
    fetch(5'd7, 32'hFF81_0113, "bypass");
    prog_we = 1'b0;
    // different-address write and fetch in one cycle
    prog_we = 1'b1; prog_addr = 5'd8; prog_data = 32'h1111_1111;
    fetch(5'd1, 32'h0140_00EF, "dual_fetch");
    prog_we = 1'b0;
    fetch(5'd8, 32'h1111_1111, "dual_write");

    // stall holds the output register
    fetch(5'd1, 32'h0140_00EF, "stall_pre");
    stall = 1'b1; fetch_req = 1'b1; fetch_addr = 5'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", instr, 32'h0140_00EF);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    fetch_req = 1'b0;
    check("stall_release", instr, 32'h00A0_0593);

    // halt
    write(5'd5, HLT);
    fetch(5'd5, HLT, "halt_instr");
    check("halt_flag", {31'b0, halted}, 32'd1);
    stall = 1'b1;
    step();
    check("halt_stall_instr", instr, HLT);
    check("halt_stall_valid", {31'b0, instr_valid}, 32'd1);
    stall = 1'b0; fetch_req = 1'b1; fetch_addr = 5'd0;
    step();
    check("halt_nofetch_valid", {31'b0, instr_valid}, 32'd0);
    check("halt_nofetch_instr", instr, NOP);
    step();
    check("halt_still_valid", {31'b0, instr_valid}, 32'd0);
    check("halt_sticky", {31'b0, halted}, 32'd1);
    check("halt_ready", {31'b0, ready}, 32'd1);

    // reset wins over everything and restarts clear; contents lost
    rst = 1'b1; prog_we = 1'b1; prog_addr = 5'd3; prog_data = 32'h2222_2222; stall = 1'b1;
    step();
    rst = 1'b0; prog_we = 1'b0; fetch_req = 1'b0; stall = 1'b0;
    check("rst2_halted", {31'b0, halted}, 32'd0);
    clear_seq();
    fetch(5'd0, NOP, "lost0");
    fetch(5'd1, NOP, "lost1");
    fetch(5'd3, NOP, "lost3");
    check("rst2_halted_run", {31'b0, halted}, 32'd0);

    // reset in the middle of clear restarts the full sequence
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("midclear_ready", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_seq();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
